// File: rtl/bootrom_arbiter.sv
// Two-port arbiter in front of a single-port synchronous boot ROM with a fixed 2-cycle response.
// Define BOOTROM_ARB_ROUND_ROBIN_EN for round-robin arbitration (default build: port 0 has fixed priority).
module bootrom_arbiter #(
  parameter int AW_ADDR_W = 8,
  parameter int DATA_W    = 32,
  parameter int ROM_WORDS = 256
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ0_VALID,
  input  logic [AW_ADDR_W-1:0] REQ0_ADDR,
  output logic                 REQ0_READY,
  output logic                 RSP0_VALID,
  output logic [DATA_W-1:0]    RSP0_DATA,
  output logic                 RSP0_ERR,
  input  logic                 REQ1_VALID,
  input  logic [AW_ADDR_W-1:0] REQ1_ADDR,
  output logic                 REQ1_READY,
  output logic                 RSP1_VALID,
  output logic [DATA_W-1:0]    RSP1_DATA,
  output logic                 RSP1_ERR,
  output logic                 ROM_EN,
  output logic [AW_ADDR_W-1:0] ROM_ADDR,
  input  logic [DATA_W-1:0]    ROM_RDATA
);

  localparam int NUM_PORTS = 2;
  localparam int STAGES    = 2;
  localparam logic [AW_ADDR_W:0] ROM_LIMIT = ROM_WORDS[AW_ADDR_W:0];

  // Per-entry sideband carried alongside the valid shift register
  typedef struct packed {
    logic port;
    logic err;
  } stg_t;

  logic [NUM_PORTS-1:0]                req_vld;
  logic [NUM_PORTS-1:0][AW_ADDR_W-1:0] req_addr;
  logic [NUM_PORTS-1:0]                req_rdy;

  logic                 gnt_port;
  logic                 accept;
  logic [AW_ADDR_W-1:0] sel_addr;
  logic                 oor;
  logic                 rom_en;

  logic [AW_ADDR_W-1:0] rom_addr_d, rom_addr_q;
  logic [STAGES:1]      vld_pipe_d, vld_pipe_q;
  stg_t                 s1_d, s1_q, s2_d, s2_q;

  logic [NUM_PORTS-1:0][DATA_W-1:0] rsp_data_d, rsp_data_q;
  logic [NUM_PORTS-1:0]             rsp_err_d, rsp_err_q;
  logic [NUM_PORTS-1:0]             rsp_vld;

  assign req_vld  = {REQ1_VALID, REQ0_VALID};
  assign req_addr = {REQ1_ADDR, REQ0_ADDR};

`ifdef BOOTROM_ARB_ROUND_ROBIN_EN
  // last_q names the port granted most recently; contention goes to the other one
  logic last_d, last_q;

  always_comb begin
    gnt_port = req_vld[1] & (~req_vld[0] | ~last_q);
    last_d   = accept ? gnt_port : last_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  always_comb begin
    gnt_port = req_vld[1] & ~req_vld[0];
  end
`endif

  always_comb begin
    accept   = (|req_vld) & ~RST;
    sel_addr = req_addr[gnt_port];
    oor      = {1'b0, sel_addr} >= ROM_LIMIT;
    rom_en   = accept & ~oor;
    req_rdy  = '0;
    req_rdy[gnt_port] = accept;
  end

  // ROM address is combinational on an access and otherwise parks on the last accessed word
  always_comb begin
    rom_addr_d = rom_addr_q;
    if (RST)         rom_addr_d = '0;
    else if (rom_en) rom_addr_d = sel_addr;
  end

  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], accept};
    s1_d.port  = gnt_port;
    s1_d.err   = oor;
    s2_d       = s1_q;
  end

  always_comb begin
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (vld_pipe_q[1] && (s1_q.port == p[0])) begin
        rsp_data_d[p] = s1_q.err ? '0 : ROM_RDATA;
        rsp_err_d[p]  = s1_q.err;
      end
    end
  end

  always_comb begin
    rsp_vld = '0;
    rsp_vld[s2_q.port] = vld_pipe_q[STAGES];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rom_addr_q <= '0;
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign REQ0_READY = req_rdy[0];
  assign REQ1_READY = req_rdy[1];
  assign ROM_EN     = rom_en;
  assign ROM_ADDR   = rom_addr_d;
  assign RSP0_VALID = rsp_vld[0];
  assign RSP1_VALID = rsp_vld[1];
  assign RSP0_DATA  = rsp_data_q[0];
  assign RSP1_DATA  = rsp_data_q[1];
  assign RSP0_ERR   = rsp_err_q[0];
  assign RSP1_ERR   = rsp_err_q[1];

endmodule
